plotter_axil_regs: RTL and testbench
====================================

Name: plotter_axil_regs

Overview:
- AXI4-Lite slave (responder) register file at the end of the plotter interconnect. Completes write and read transactions issued by the PS or VIP master.
- Holds NUM_REGS 32-bit read/write control words: control, X step target, Y step target, step rate. Drives them to the stepper-motor core, with a one-cycle write pulse per register.
- Always answers OKAY.

Parameters:
- DATA_WIDTH, 32, AXI data width; only 32 is supported.
- ADDR_WIDTH, 4, AXI address width; register index = addr[ADDR_WIDTH-1:2], addr[1:0] ignored.
- NUM_REGS, 4, register count; must equal 2**(ADDR_WIDTH-2).

Ports:
- ACLK  in  1  sole clock, rising edge.
- ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake.
- S_AXI_BRESP  out  2  always 2'b00.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake.
- S_AXI_ARADDR  in  ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake.
- S_AXI_RDATA  out  32  registered read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake.
- reg_out  out  NUM_REGS*32  register contents; reg i = bits [32i+31:32i].
- reg_wr_pulse  out  NUM_REGS  bit i high for exactly one cycle after a write commits to reg i.

Behaviour:
- Reset: all regs 0, reg_wr_pulse 0, AWREADY/WREADY/ARREADY/BVALID/RVALID 0, RDATA 0. Both FSMs go to their idle state. Any in-flight transaction is dropped with no response. While ARESET is high all readies are 0. In the first cycle after release, AWREADY=WREADY=ARREADY=1.
- Write FSM states: W_IDLE, W_GOT_AW, W_GOT_W, W_RESP.
  - AWREADY=1 in W_IDLE and W_GOT_W. WREADY=1 in W_IDLE and W_GOT_AW.
  - W_IDLE, AW and W handshakes in the same cycle: commit at that edge, go to W_RESP.
  - W_IDLE, AW handshake only: latch AWADDR, go to W_GOT_AW. W handshake only: latch WDATA/WSTRB, go to W_GOT_W.
  - W_GOT_AW: commit on the W handshake, go to W_RESP. W_GOT_W: commit on the AW handshake, go to W_RESP.
  - Commit: for each byte b with WSTRB[b]=1, reg[idx][8b+7:8b] <= WDATA byte b; other bytes hold. reg_wr_pulse[idx] is 1 in the following cycle, even if WSTRB=0.
  - BVALID=1 in W_RESP and holds until BREADY. On B handshake go to W_IDLE, readies return next cycle.
  - Latency: commit edge N, so reg_out updated, BVALID and pulse all visible in cycle N+1.
- Read FSM states: R_IDLE, R_VALID.
  - ARREADY=1 only in R_IDLE.
  - AR handshake at edge N: RDATA <= reg[ARADDR idx] as sampled before any same-edge write commit, so a same-edge write to that reg returns the old value. RVALID=1 in cycle N+1.
  - RDATA and RVALID hold stable until RREADY, then return to R_IDLE.
- Read and write channels are fully independent and may run concurrently.
- Back-to-back throughput: one write per 2 cycles, one read per 2 cycles.
- PROT is ignored; no address decode error exists.

Decomposition:
- Package plotter_axil_pkg: AXI_RESP_OKAY constant, write-state and read-state enums, REG_CTRL/REG_XTGT/REG_YTGT/REG_RATE index constants.
- No sub-module. Write FSM, read FSM and register array live in one module.

Test Plan:
- Sequential AW+W writes of 0x1..0x4 to addr 0x0,0x4,0x8,0xC, then reads of the same addresses -> RDATA 0x1,0x2,0x3,0x4, BRESP/RRESP=0, reg_wr_pulse 0001,0010,0100,1000 in turn.
- AW to 0x8 three cycles before W=0xDEADBEEF, then the reverse order to 0x4 -> both commit, B returned only after the second handshake, reg_out values match.
- Write 0xFFFFFFFF to 0x0, then 0x12345678 with WSTRB=0101 -> read returns 0xFF34FF78.
- BREADY held low 5 cycles -> BVALID stays 1, AWREADY/WREADY stay 0. RREADY held low -> RDATA stable, ARREADY 0.
- Read and write to 0xC handshaken in the same cycle (old 0x4, new 0x99) -> RDATA 0x4, subsequent read 0x99.
- ARESET asserted in W_GOT_AW with reg1=0x2 -> all regs 0, no BVALID. After release, a full write to 0x4 completes normally.

Source files
------------

// File: rtl/plotter_axil_pkg.sv
// plotter_axil_pkg
//   Shared definitions for the plotter AXI4-Lite register file:
//   response code, write/read FSM state encodings, register index map
//   and the byte-strobe merge helper used when a write commits.
package plotter_axil_pkg;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Register index map (word index = byte address >> 2).
    localparam int REG_CTRL = 0;
    localparam int REG_XTGT = 1;
    localparam int REG_YTGT = 2;
    localparam int REG_RATE = 3;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_GOT_AW = 2'd1,
        W_GOT_W  = 2'd2,
        W_RESP   = 2'd3
    } wr_state_e;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_VALID = 1'b1
    } rd_state_e;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/plotter_axil_regs.sv
// plotter_axil_regs
//   AXI4-Lite responder holding NUM_REGS 32-bit control words for the
//   stepper-motor core (control, X target, Y target, step rate).
//
//   Handshake rule: a channel transfer happens on a rising ACLK edge where
//   both VALID and READY are high. VALID from this block (BVALID, RVALID)
//   holds with its payload stable until the matching READY is seen.
//
//   Ports:
//     ACLK, ARESET           clock, synchronous active-high reset
//     S_AXI_AW*/W*/B*        write address, data and response channels
//     S_AXI_AR*/R*           read address and data channels
//     reg_out                register i on bits [32i+31:32i]
//     reg_wr_pulse           bit i high for one cycle after a write to reg i
module plotter_axil_regs
    import plotter_axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 4
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [ADDR_WIDTH-1:0]    S_AXI_AWADDR,
    input  logic [2:0]               S_AXI_AWPROT,
    input  logic                     S_AXI_AWVALID,
    output logic                     S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]    S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]  S_AXI_WSTRB,
    input  logic                     S_AXI_WVALID,
    output logic                     S_AXI_WREADY,
    output logic [1:0]               S_AXI_BRESP,
    output logic                     S_AXI_BVALID,
    input  logic                     S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]    S_AXI_ARADDR,
    input  logic [2:0]               S_AXI_ARPROT,
    input  logic                     S_AXI_ARVALID,
    output logic                     S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]    S_AXI_RDATA,
    output logic [1:0]               S_AXI_RRESP,
    output logic                     S_AXI_RVALID,
    input  logic                     S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]   reg_out,
    output logic [NUM_REGS-1:0]      reg_wr_pulse
);

    localparam int IDX_W = ADDR_WIDTH - 2;

    wr_state_e         wr_state;
    rd_state_e         rd_state;
    logic [31:0]       regs [NUM_REGS];
    logic [IDX_W-1:0]  aw_idx_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;

    logic              commit_en;
    logic [IDX_W-1:0]  commit_idx;
    logic [31:0]       commit_data;
    logic [3:0]        commit_strb;

    // PROT and the byte-offset address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Readies decode straight from state; gating with ARESET keeps them low
    // for the whole reset window and lets them rise in the first cycle after.
    assign S_AXI_AWREADY = !ARESET && (wr_state == W_IDLE || wr_state == W_GOT_W);
    assign S_AXI_WREADY  = !ARESET && (wr_state == W_IDLE || wr_state == W_GOT_AW);
    assign S_AXI_ARREADY = !ARESET && (rd_state == R_IDLE);
    assign S_AXI_BRESP   = AXI_RESP_OKAY;
    assign S_AXI_RRESP   = AXI_RESP_OKAY;

    // A commit happens on the edge where the second of the AW/W pair lands
    // (or both together from idle); payload comes from whichever half was
    // latched earlier.
    always_comb begin
        commit_en   = 1'b0;
        commit_idx  = aw_idx_q;
        commit_data = S_AXI_WDATA;
        commit_strb = S_AXI_WSTRB;
        case (wr_state)
            W_IDLE: begin
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    commit_en  = 1'b1;
                    commit_idx = S_AXI_AWADDR[ADDR_WIDTH-1:2];
                end
            end
            W_GOT_AW: begin
                if (S_AXI_WVALID) commit_en = 1'b1;
            end
            W_GOT_W: begin
                if (S_AXI_AWVALID) begin
                    commit_en   = 1'b1;
                    commit_idx  = S_AXI_AWADDR[ADDR_WIDTH-1:2];
                    commit_data = wdata_q;
                    commit_strb = wstrb_q;
                end
            end
            default: ;
        endcase
    end

    // Write FSM and register array.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state     <= W_IDLE;
            S_AXI_BVALID <= 1'b0;
            reg_wr_pulse <= '0;
            aw_idx_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            reg_wr_pulse <= '0;
            if (commit_en) begin
                regs[commit_idx]         <= apply_wstrb(regs[commit_idx], commit_data, commit_strb);
                reg_wr_pulse[commit_idx] <= 1'b1;
                S_AXI_BVALID             <= 1'b1;
                wr_state                 <= W_RESP;
            end else begin
                case (wr_state)
                    W_IDLE: begin
                        if (S_AXI_AWVALID) begin
                            aw_idx_q <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
                            wr_state <= W_GOT_AW;
                        end else if (S_AXI_WVALID) begin
                            wdata_q  <= S_AXI_WDATA;
                            wstrb_q  <= S_AXI_WSTRB;
                            wr_state <= W_GOT_W;
                        end
                    end
                    W_RESP: begin
                        if (S_AXI_BREADY) begin
                            S_AXI_BVALID <= 1'b0;
                            wr_state     <= W_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read FSM. regs is sampled before this edge's write lands, so a
    // same-edge write to the addressed register returns the old value.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state     <= R_IDLE;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (S_AXI_ARVALID) begin
                        S_AXI_RDATA  <= regs[S_AXI_ARADDR[ADDR_WIDTH-1:2]];
                        S_AXI_RVALID <= 1'b1;
                        rd_state     <= R_VALID;
                    end
                end
                R_VALID: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID <= 1'b0;
                        rd_state     <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
        assign reg_out[32*i +: 32] = regs[i];
    end

endmodule

// File: tb/tb_plotter_axil_regs.sv
// tb_plotter_axil_regs
//   Self-checking bench for plotter_axil_regs: directed scenarios followed
//   by randomized reads/writes, compared against an array model of the
//   four registers and a queue of expected read data.
module tb_plotter_axil_regs;
    import plotter_axil_pkg::*;

    logic         clk = 1'b0;
    logic         ARESET;
    logic [3:0]   S_AXI_AWADDR;
    logic [2:0]   S_AXI_AWPROT;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [3:0]   S_AXI_ARADDR;
    logic [2:0]   S_AXI_ARPROT;
    logic         S_AXI_ARVALID;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY;
    logic [127:0] reg_out;
    logic [3:0]   reg_wr_pulse;

    plotter_axil_regs dut (
        .ACLK          (clk),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .reg_out       (reg_out),
        .reg_wr_pulse  (reg_wr_pulse)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model [4];
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) check(tag, reg_out[32*i +: 32], model[i]);
    endtask

    // ---------------- driver tasks ----------------
    // All tasks start and end at posedge+#1.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly,
                             input int w_dly, input int b_dly);
        bit          aw_done = 0;
        bit          w_done  = 0;
        bit          aw_hs, w_hs;
        int          cyc = 0;
        int          idx;
        logic [3:0]  exp_pulse;
        idx = int'(addr[3:2]);
        S_AXI_AWADDR = addr;
        S_AXI_WDATA  = data;
        S_AXI_WSTRB  = strb;
        while (!(aw_done && w_done) && cyc < 50) begin
            S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
            S_AXI_WVALID  = !w_done  && (cyc >= w_dly);
            @(negedge clk);
            if (aw_done != w_done) check("b_early", S_AXI_BVALID, 0);
            if (aw_done && !w_done) check("awready_got_aw", S_AXI_AWREADY, 0);
            if (w_done && !aw_done) check("wready_got_w", S_AXI_WREADY, 0);
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge clk); #1;
            aw_done = aw_done | aw_hs;
            w_done  = w_done | w_hs;
            cyc++;
        end
        S_AXI_AWVALID = 0;
        S_AXI_WVALID  = 0;
        if (!(aw_done && w_done)) begin
            check("aw_w_timeout", 0, 1);
            return;
        end
        for (int b = 0; b < 4; b++)
            if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        exp_pulse = 4'b0001 << idx;
        check("wr_pulse", {28'h0, reg_wr_pulse}, {28'h0, exp_pulse});
        check("bvalid_rise", S_AXI_BVALID, 1);
        check_regs("reg_out_after_wr");
        for (int i = 0; i < b_dly; i++) begin
            @(negedge clk);
            check("bvalid_hold", S_AXI_BVALID, 1);
            check("awready_in_resp", S_AXI_AWREADY, 0);
            check("wready_in_resp", S_AXI_WREADY, 0);
            @(posedge clk); #1;
        end
        S_AXI_BREADY = 1;
        @(negedge clk);
        check("bvalid_at_hs", S_AXI_BVALID, 1);
        check("bresp", {30'h0, S_AXI_BRESP}, {30'h0, AXI_RESP_OKAY});
        @(posedge clk); #1;
        S_AXI_BREADY = 0;
        check("bvalid_fall", S_AXI_BVALID, 0);
        check("wr_pulse_clear", {28'h0, reg_wr_pulse}, 0);
        check("awready_back", S_AXI_AWREADY, 1);
        check("wready_back", S_AXI_WREADY, 1);
    endtask

    task automatic axi_read(input logic [3:0] addr, input int r_dly);
        bit          hs = 0;
        int          cyc = 0;
        logic [31:0] held;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1;
        while (!hs && cyc < 50) begin
            @(negedge clk);
            // Expected value is the register content before this edge.
            if (S_AXI_ARREADY) begin
                hs = 1;
                exp_q.push_back(model[int'(addr[3:2])]);
            end
            @(posedge clk); #1;
            cyc++;
        end
        S_AXI_ARVALID = 0;
        if (!hs) begin
            check("ar_timeout", 0, 1);
            return;
        end
        check("rvalid_rise", S_AXI_RVALID, 1);
        held = S_AXI_RDATA;
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clk);
            check("rdata_hold", S_AXI_RDATA, held);
            check("rvalid_hold", S_AXI_RVALID, 1);
            check("arready_busy", S_AXI_ARREADY, 0);
            @(posedge clk); #1;
        end
        S_AXI_RREADY = 1;
        @(negedge clk);
        check("rvalid_at_hs", S_AXI_RVALID, 1);
        check("rdata", S_AXI_RDATA, exp_q.pop_front());
        check("rresp", {30'h0, S_AXI_RRESP}, {30'h0, AXI_RESP_OKAY});
        @(posedge clk); #1;
        S_AXI_RREADY = 0;
        check("rvalid_fall", S_AXI_RVALID, 0);
        check("arready_back", S_AXI_ARREADY, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        ARESET        = 1;
        S_AXI_AWADDR  = '0;
        S_AXI_AWPROT  = '0;
        S_AXI_AWVALID = 0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = '0;
        S_AXI_WVALID  = 0;
        S_AXI_BREADY  = 0;
        S_AXI_ARADDR  = '0;
        S_AXI_ARPROT  = '0;
        S_AXI_ARVALID = 0;
        S_AXI_RREADY  = 0;
        for (int i = 0; i < 4; i++) model[i] = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", S_AXI_AWREADY, 0);
        check("rst_wready", S_AXI_WREADY, 0);
        check("rst_arready", S_AXI_ARREADY, 0);
        check("rst_bvalid", S_AXI_BVALID, 0);
        check("rst_rvalid", S_AXI_RVALID, 0);
        check("rst_rdata", S_AXI_RDATA, 0);
        check("rst_pulse", {28'h0, reg_wr_pulse}, 0);
        check_regs("rst_reg_out");
        ARESET = 0;
        #1;
        check("rel_awready", S_AXI_AWREADY, 1);
        check("rel_wready", S_AXI_WREADY, 1);
        check("rel_arready", S_AXI_ARREADY, 1);

        // Sequential writes 1..4 then read-back.
        for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);

        // Split AW/W ordering both ways.
        axi_write(4'(REG_YTGT * 4), 32'hDEADBEEF, 4'hF, 0, 3, 0);
        axi_write(4'(REG_XTGT * 4), 32'hCAFEF00D, 4'hF, 3, 0, 0);

        // Byte strobes.
        axi_write(4'(REG_CTRL * 4), 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        axi_write(4'(REG_CTRL * 4), 32'h12345678, 4'b0101, 0, 0, 0);
        axi_read(4'(REG_CTRL * 4), 0);
        // Strobe of zero still pulses, contents unchanged.
        axi_write(4'(REG_YTGT * 4), 32'h55555555, 4'b0000, 0, 0, 0);

        // Backpressure on B and R.
        axi_write(4'(REG_XTGT * 4), 32'hA5A5A5A5, 4'hF, 0, 0, 5);
        axi_read(4'(REG_XTGT * 4), 5);

        // Same-edge read and write of the rate register: read sees old value.
        fork
            axi_write(4'(REG_RATE * 4), 32'h00000099, 4'hF, 0, 0, 0);
            axi_read(4'(REG_RATE * 4), 0);
        join
        axi_read(4'(REG_RATE * 4), 0);

        // Reset with a write parked in W_GOT_AW.
        axi_write(4'(REG_XTGT * 4), 32'h00000002, 4'hF, 0, 0, 0);
        S_AXI_AWADDR  = 4'(REG_XTGT * 4);
        S_AXI_AWVALID = 1;
        @(posedge clk); #1;
        S_AXI_AWVALID = 0;
        check("got_aw_awready", S_AXI_AWREADY, 0);
        ARESET = 1;
        @(posedge clk); #1;
        check("mid_rst_awready", S_AXI_AWREADY, 0);
        check("mid_rst_wready", S_AXI_WREADY, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) model[i] = '0;
        check("mid_rst_bvalid", S_AXI_BVALID, 0);
        check_regs("mid_rst_reg_out");
        ARESET = 0;
        #1;
        check("post_rst_awready", S_AXI_AWREADY, 1);
        @(posedge clk); #1;
        check("post_rst_no_b", S_AXI_BVALID, 0);
        axi_write(4'(REG_XTGT * 4), 32'h0BADC0DE, 4'hF, 0, 0, 0);
        axi_read(4'(REG_XTGT * 4), 0);

        // Randomized mix of writes, reads and overlapped pairs.
        for (int n = 0; n < 60; n++) begin
            int          op;
            logic [3:0]  wa, ra;
            logic [31:0] wd;
            logic [3:0]  ws;
            op = $urandom_range(0, 2);
            wa = 4'($urandom_range(0, 15));
            ra = 4'($urandom_range(0, 15));
            wd = $urandom;
            ws = 4'($urandom_range(0, 15));
            case (op)
                0: axi_write(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                1: axi_read(ra, $urandom_range(0, 3));
                default: fork
                    axi_write(wa, wd, ws, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
                    axi_read(ra, $urandom_range(0, 2));
                join
            endcase
        end
        check_regs("final_reg_out");
        check("exp_q_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
